// File: rtl/octal_step_counter_if.sv
// Board-side signal bundle for the octal step counter: raw buttons, preset and
// display enable in; 3-bit digit, display enable and wrap pulse out.
interface octal_step_counter_if;
  logic       btn_inc;
  logic       btn_dec;
  logic       load;
  logic [2:0] sw;
  logic       disp_on;
  logic [2:0] b;
  logic       en;
  logic       wrap;

  modport master (
    output btn_inc, btn_dec, load, sw, disp_on,
    input  b, en, wrap
  );

  modport slave (
    input  btn_inc, btn_dec, load, sw, disp_on,
    output b, en, wrap
  );
endinterface

// File: rtl/octal_step_counter.sv
// Modulo-8 step counter driven by two debounced push-buttons, with preset load
// and wrap pulse. Define OCT_STEP_BLINK_EN to compile in the display blink.
module octal_step_counter #(
  parameter int DEB_CYCLES = 500000,
  parameter int BLINK_HALF = 12500000
) (
  input logic                 clk,
  input logic                 rst,
  octal_step_counter_if.slave io
);
  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 2 || BLINK_HALF < 1) begin : g_param_check
    $error("octal_step_counter: DEB_CYCLES must be >= 2 and BLINK_HALF >= 1");
  end

  // Bit 0 is the increment button path, bit 1 the decrement path.
  logic [1:0]            s1_q, s1_d;
  logic [1:0]            s2_q, s2_d;
  logic [1:0]            deb_q, deb_d;
  logic [1:0]            deb_prev_q, deb_prev_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            press;

  logic [2:0] b_q, b_d;
  logic       wrap_q, wrap_d;
  logic       en_q, en_d;

  always_comb begin
    s1_d       = {io.btn_dec, io.btn_inc};
    s2_d       = s1_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    cnt_d      = '0;
    for (int i = 0; i < 2; i++) begin
      // Any cycle where s2 agrees with the debounced state restarts qualification.
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    press = deb_q & ~deb_prev_q;
  end

  always_comb begin
    b_d    = b_q;
    wrap_d = 1'b0;
    if (io.load) begin
      b_d = io.sw;
    end else if (press == 2'b01) begin
      b_d    = b_q + 3'd1;
      wrap_d = (b_q == 3'd7);
    end else if (press == 2'b10) begin
      b_d    = b_q - 3'd1;
      wrap_d = (b_q == 3'd0);
    end
  end

`ifdef OCT_STEP_BLINK_EN
  localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             phase_q, phase_d;
  logic             b_change;

  assign b_change = io.load | (press == 2'b01) | (press == 2'b10);

  // A fresh value restarts the blink in the visible phase so it shows at once.
  always_comb begin
    blk_cnt_d = blk_cnt_q + BLK_W'(1);
    phase_d   = phase_q;
    if (b_change) begin
      blk_cnt_d = '0;
      phase_d   = 1'b1;
    end else if (blk_cnt_q == BLK_LAST) begin
      blk_cnt_d = '0;
      phase_d   = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_q <= '0;
      phase_q   <= 1'b1;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      phase_q   <= phase_d;
    end
  end

  assign en_d = io.disp_on & phase_d;
`else
  assign en_d = io.disp_on;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '0;
      b_q        <= '0;
      wrap_q     <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q      <= cnt_d;
      b_q        <= b_d;
      wrap_q     <= wrap_d;
      en_q       <= en_d;
    end
  end

  assign io.b    = b_q;
  assign io.wrap = wrap_q;
  assign io.en   = en_q;
endmodule

// File: tb/tb_octal_step_counter.sv
// Self-checking bench for octal_step_counter: directed scenarios plus a random
// run against a window-based behavioural model of debounce, count and blink.
module tb_octal_step_counter;
  localparam int DEB = 4;
  localparam int BLK = 8;

  logic clk = 1'b0;
  logic rst;
  octal_step_counter_if io ();

  octal_step_counter #(.DEB_CYCLES(DEB), .BLINK_HALF(BLK)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         edge_n = 0;
  int         last_r = 0;
  logic [1:0] raw_hist[$];
  logic [1:0] s2_hist[$];
  logic [1:0] deb_m  = '0;
  logic [1:0] rose_m = '0;
  logic [2:0] b_m    = '0;
  logic       wrap_m = 1'b0;
  logic       en_m   = 1'b0;

  // A debounced state flips once the last DEB synchronised samples all disagree
  // with it; a rise is seen as a step one edge later.
  task automatic model_edge();
    logic [1:0] s2_now;
    logic [1:0] ev;
    logic       changed;
    logic       phase;
    bit         all_diff;
    if (rst) begin
      raw_hist.delete();
      s2_hist.delete();
      deb_m  = '0;
      rose_m = '0;
      b_m    = '0;
      wrap_m = 1'b0;
      en_m   = 1'b0;
      last_r = edge_n;
    end else begin
      s2_now = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 2'b00;
      raw_hist.push_back({io.btn_dec, io.btn_inc});
      s2_hist.push_back(s2_now);
      if (raw_hist.size() > 4) void'(raw_hist.pop_front());
      if (s2_hist.size() > DEB) void'(s2_hist.pop_front());
      ev      = rose_m;
      changed = 1'b0;
      wrap_m  = 1'b0;
      if (io.load) begin
        b_m = io.sw;
        changed = 1'b1;
      end else if (ev == 2'b01) begin
        wrap_m = (b_m == 3'd7);
        b_m = b_m + 3'd1;
        changed = 1'b1;
      end else if (ev == 2'b10) begin
        wrap_m = (b_m == 3'd0);
        b_m = b_m - 3'd1;
        changed = 1'b1;
      end
      rose_m = 2'b00;
      for (int i = 0; i < 2; i++) begin
        all_diff = (s2_hist.size() == DEB);
        foreach (s2_hist[k]) if (s2_hist[k][i] == deb_m[i]) all_diff = 0;
        if (all_diff) begin
          deb_m[i]  = ~deb_m[i];
          rose_m[i] = deb_m[i];
        end
      end
      if (changed) last_r = edge_n;
`ifdef OCT_STEP_BLINK_EN
      phase = (((edge_n - last_r) / BLK) % 2) == 0;
`else
      phase = 1'b1;
`endif
      en_m = io.disp_on & phase;
    end
    edge_n++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    io.btn_inc = 1'b0; io.btn_dec = 1'b0; io.load = 1'b0; io.sw = 3'd0; io.disp_on = 1'b1;
    repeat (3) tick();
    total++; if (io.b !== 3'd0)   begin bad++; $display("FAIL reset_b: got %0d want 0", io.b); end
    total++; if (io.en !== 1'b0)  begin bad++; $display("FAIL reset_en: got %0b want 0", io.en); end
    total++; if (io.wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %0b want 0", io.wrap); end
    rst = 1'b0;
    tick();
    total++; if (io.b !== 3'd0)   begin bad++; $display("FAIL post_reset_b: got %0d want 0", io.b); end
    total++; if (io.wrap !== 1'b0) begin bad++; $display("FAIL post_reset_wrap: got %0b want 0", io.wrap); end
    total++; if (io.en !== 1'b1)  begin bad++; $display("FAIL post_reset_en: got %0b want 1", io.en); end
  endtask

  task automatic test_clean_press();
    io.btn_inc = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t == 6) begin
        total++; if (io.b !== 3'd0) begin bad++; $display("FAIL step_edge6: got %0d want 0", io.b); end
      end
      if (t == 7) begin
        total++; if (io.b !== 3'd1) begin bad++; $display("FAIL step_edge7: got %0d want 1", io.b); end
      end
    end
    total++; if (io.b !== 3'd1) begin bad++; $display("FAIL held_one_step: got %0d want 1", io.b); end
    io.btn_inc = 1'b0;
    repeat (10) tick();
    total++; if (io.b !== 3'd1) begin bad++; $display("FAIL release_no_step: got %0d want 1", io.b); end
    io.btn_inc = 1'b1;
    repeat (7) tick();
    total++; if (io.b !== 3'd2) begin bad++; $display("FAIL second_press: got %0d want 2", io.b); end
    io.btn_inc = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_bounce();
    io.btn_inc = 1'b1; tick();
    io.btn_inc = 1'b0; tick();
    io.btn_inc = 1'b1; tick();
    io.btn_inc = 1'b0; tick();
    io.btn_inc = 1'b1;
    repeat (6) tick();
    total++; if (io.b !== 3'd2) begin bad++; $display("FAIL bounce_early: got %0d want 2", io.b); end
    tick();
    total++; if (io.b !== 3'd3) begin bad++; $display("FAIL bounce_step: got %0d want 3", io.b); end
    io.btn_inc = 1'b0;
    repeat (10) tick();
    total++; if (io.b !== 3'd3) begin bad++; $display("FAIL bounce_single: got %0d want 3", io.b); end
  endtask

  task automatic test_wrap();
    io.load = 1'b1; io.sw = 3'd7;
    tick();
    io.load = 1'b0;
    total++; if (io.b !== 3'd7) begin bad++; $display("FAIL load7: got %0d want 7", io.b); end
    io.btn_inc = 1'b1;
    repeat (7) tick();
    total++; if (io.b !== 3'd0)    begin bad++; $display("FAIL inc_wrap_b: got %0d want 0", io.b); end
    total++; if (io.wrap !== 1'b1) begin bad++; $display("FAIL inc_wrap_pulse: got %0b want 1", io.wrap); end
    tick();
    total++; if (io.wrap !== 1'b0) begin bad++; $display("FAIL inc_wrap_width: got %0b want 0", io.wrap); end
    io.btn_inc = 1'b0;
    repeat (10) tick();
    io.btn_dec = 1'b1;
    repeat (7) tick();
    total++; if (io.b !== 3'd7)    begin bad++; $display("FAIL dec_wrap_b: got %0d want 7", io.b); end
    total++; if (io.wrap !== 1'b1) begin bad++; $display("FAIL dec_wrap_pulse: got %0b want 1", io.wrap); end
    tick();
    total++; if (io.wrap !== 1'b0) begin bad++; $display("FAIL dec_wrap_width: got %0b want 0", io.wrap); end
    io.btn_dec = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_collision();
    io.btn_inc = 1'b1; io.btn_dec = 1'b1;
    repeat (7) tick();
    total++; if (io.b !== 3'd7)    begin bad++; $display("FAIL cancel_b: got %0d want 7", io.b); end
    total++; if (io.wrap !== 1'b0) begin bad++; $display("FAIL cancel_wrap: got %0b want 0", io.wrap); end
    io.btn_inc = 1'b0; io.btn_dec = 1'b0;
    repeat (10) tick();
    io.btn_inc = 1'b1;
    repeat (6) tick();
    io.load = 1'b1; io.sw = 3'd3;
    tick();
    io.load = 1'b0;
    total++; if (io.b !== 3'd3)    begin bad++; $display("FAIL load_over_step: got %0d want 3", io.b); end
    total++; if (io.wrap !== 1'b0) begin bad++; $display("FAIL load_over_step_wrap: got %0b want 0", io.wrap); end
    tick();
    total++; if (io.b !== 3'd3) begin bad++; $display("FAIL step_dropped: got %0d want 3", io.b); end
    io.btn_inc = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_random();
    int run_inc = 0;
    int run_dec = 0;
    for (int c = 0; c < 2000; c++) begin
      if (run_inc == 0) begin
        io.btn_inc = ~io.btn_inc;
        run_inc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 14);
      end
      if (run_dec == 0) begin
        io.btn_dec = ~io.btn_dec;
        run_dec = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 14);
      end
      run_inc--;
      run_dec--;
      io.load = ($urandom_range(0, 29) == 0);
      io.sw   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) io.disp_on = ~io.disp_on;
      rst = ($urandom_range(0, 399) == 0);
      tick();
      total++; if (io.b !== b_m)       begin bad++; $display("FAIL rand_b c=%0d: got %0d want %0d", c, io.b, b_m); end
      total++; if (io.wrap !== wrap_m) begin bad++; $display("FAIL rand_wrap c=%0d: got %0b want %0b", c, io.wrap, wrap_m); end
      total++; if (io.en !== en_m)     begin bad++; $display("FAIL rand_en c=%0d: got %0b want %0b", c, io.en, en_m); end
    end
    rst = 1'b0; io.load = 1'b0; io.btn_inc = 1'b0; io.btn_dec = 1'b0; io.disp_on = 1'b1;
    repeat (10) tick();
  endtask

`ifdef OCT_STEP_BLINK_EN
  task automatic test_blink();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      total++; if (io.en !== (t < 8)) begin bad++; $display("FAIL blink_phase t=%0d: got %0b want %0b", t, io.en, (t < 8)); end
    end
    io.load = 1'b1; io.sw = 3'd5;
    tick();
    io.load = 1'b0;
    total++; if (io.en !== 1'b1) begin bad++; $display("FAIL blink_load_en: got %0b want 1", io.en); end
    total++; if (io.b !== 3'd5)  begin bad++; $display("FAIL blink_load_b: got %0d want 5", io.b); end
    for (int t = 1; t <= 8; t++) begin
      tick();
      total++; if (io.en !== (t < 8)) begin bad++; $display("FAIL blink_restart t=%0d: got %0b want %0b", t, io.en, (t < 8)); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_wrap();
    test_collision();
    test_random();
`ifdef OCT_STEP_BLINK_EN
    test_blink();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/octal_step_counter.md
# octal_step_counter

Button-driven modulo-8 step counter that produces the 3-bit digit value and display enable consumed by the 3-bit seven-segment decoder on the board. Two mechanical push-buttons (increment, decrement) are synchronised and debounced internally. A synchronous load path presets the value from slide switches. A one-cycle wrap pulse is provided for chaining or LED indication.

## Interface
Parameters:
- DEB_CYCLES, 500000 — consecutive stable cycles needed before a debounced button state changes; ≥ 2
- BLINK_HALF, 12500000 — half-period of display blink in cycles; used only when blink is compiled in; ≥ 1

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- btn_inc  in  1  raw increment button, active-high, asynchronous to clk
- btn_dec  in  1  raw decrement button, active-high, asynchronous to clk
- load  in  1  synchronous preset strobe (level, sampled each cycle)
- sw  in  3  preset value
- disp_on  in  1  display master enable
- b  out  3  current count, to decoder value input
- en  out  1  display enable, to decoder enable input
- wrap  out  1  one-cycle pulse on 7→0 (inc) or 0→7 (dec)

## Operation
- Reset (rst=1 at an edge): b=0, en=0, wrap=0. Synchronisers, debounced states, stability counters and blink state all clear. Takes priority over every other input.
- Each button path has five stages:
  - Synchroniser: two flops (s1, s2).
  - Stability counter: cleared whenever s2 equals the debounced state. Increments while they differ.
  - Debounced-state update: when the counter is at DEB_CYCLES-1 and s2 still differs, the debounced state takes s2 and the counter clears.
  - Bounce rejection: any glitch shorter than DEB_CYCLES cycles after synchronisation is discarded.
  - Press event: debounced rising edge (debounced=1, previous-cycle debounced=0). This is a one-cycle internal pulse. A release generates nothing.
- Count update, priority order per cycle:
  1. load=1: b ← sw. Step events that cycle are dropped. wrap=0.
  2. Inc event and dec event in the same cycle: cancel; b unchanged, wrap=0.
  3. Inc event only: b ← b+1 mod 8. wrap=1 iff old b=7.
  4. Dec event only: b ← b−1 mod 8. wrap=1 iff old b=0.
  5. Otherwise: b holds, wrap=0.
- Holding a button produces exactly one step. There is no auto-repeat.
- en is registered: en ← disp_on, modified by blink when compiled in (see Configuration).
- Reset asserted mid-debounce discards the partial count. A button still held after reset release must be re-qualified, and produces a step once stable for DEB_CYCLES.

## Timing
- Step latency: button changes before edge 0, then held stable → b and wrap update at edge DEB_CYCLES+3.
  - s1 at edge 1, s2 at edge 2.
  - Debounced state at edge DEB_CYCLES+2.
  - Count at edge DEB_CYCLES+3.
- load latency: 1 cycle. Value sampled at edge N is visible on b after edge N.
- wrap is high for exactly the one cycle following the wrapping update.
- en follows disp_on with 1-cycle latency.
- Minimum re-press interval: DEB_CYCLES for release plus DEB_CYCLES for press, each after synchronisation.

## Configuration
- Macro OCT_STEP_BLINK_EN.
- Defined:
  - A BLINK_HALF-cycle counter toggles a blink phase; phase resets to 1.
  - en ← disp_on & phase.
  - Any change of b (load, step or wrap) clears the blink counter and forces phase=1 on the same edge, so a new value is always shown immediately.
- Undefined:
  - No blink counter is synthesised.
  - en ← disp_on.
  - BLINK_HALF is ignored.

## Test plan
Bench uses DEB_CYCLES=4 and BLINK_HALF=8.
- Reset, then rst=0 with disp_on=1 → b=0, wrap=0; en=1 one cycle after reset release (blink off).
- Clean btn_inc held 20 cycles from edge 0 → b=1 at edge 7 exactly, and exactly one step total; release then press again → b=2.
- btn_inc bounced 1-0-1-0 (1-cycle pulses) then held → no step from the glitches; a single step 7 edges after the final stable rise.
- load=1 with sw=7, then clean inc press → b=7, then b=0 with wrap=1 for exactly one cycle; then dec press → b=7 with a wrap pulse.
- inc and dec debounced events landing on the same edge → b unchanged, wrap=0; load asserted on a step-event edge with sw=3 → b=3.
- With OCT_STEP_BLINK_EN and disp_on=1 → en toggles every 8 cycles; load sw=5 during phase 0 → en=1 on the next cycle and phase restarts.
